uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Transmit-side UART controller. Accepts one data word per valid/ready handshake and serialises it onto tx_o.
//  Frame format is start bit, data LSB first, optional parity bit, then stop bit(s).
//  Contains its own baud-tick counter of CLOCK/BAUD_RATE cycles per bit and sequences it with the frame FSM.
//  Sits between the core's memory-mapped UART register (producer) and the TX pad.
// PARAMETERS
//  CLOCK        100e6       system clock frequency, Hz
//  BAUD_RATE    20000000    line rate, bit/s
//  BAUD_COUNTER CLOCK/BAUD_RATE  clocks per bit (B); default 5; must be >=1
//  DATA_BITS    8           data bits per frame (D), 5..9
//  PARITY_EN    0           1 = append parity bit (P=1), else P=0
//  PARITY_ODD   0           1 = odd parity, 0 = even parity
//  STOP_BITS    1           stop bits per frame (S), 1 or 2
// PORTS
//  clk_i        in   1          system clock, rising edge
//  rst_ni       in   1          asynchronous active-low reset
//  tx_data_i    in   DATA_BITS  word to send; sampled only on handshake
//  tx_valid_i   in   1          producer has a word
//  tx_ready_o   out  1          controller can accept a word (combinational: state==IDLE)
//  tx_o         out  1          serial line, registered, idle high
//  busy_o       out  1          high while a frame is in progress (state!=IDLE)
//  done_o       out  1          one-cycle pulse when a frame has fully completed
// BEHAVIOUR
//  Reset (rst_ni=0, asynchronous): state=IDLE, tx_o=1, done_o=0, busy_o=0; the baud counter, bit index and shift reg are cleared.
//   While rst_ni=0, tx_ready_o reads 1 but tx_valid_i is ignored.
//  Reset mid-frame: tx_o returns to 1 immediately and the frame is abandoned; no done_o pulse.
//  FSM states are IDLE, START, DATA, PARITY, STOP.
//   IDLE: tx_o=1. On tx_valid_i&&tx_ready_o in cycle T, tx_data_i is latched into the shift reg and state goes to START at T+1.
//   START: tx_o=0 for B cycles.
//   DATA: bit i (i=0..D-1, LSB first) is driven for B cycles each. Go to PARITY if PARITY_EN, else go to STOP.
//   PARITY: drive ^data (even) or ~^data (odd) for B cycles; the value comes from the latched word, not the shift reg.
//   STOP: tx_o=1 for S*B cycles, then go to IDLE.
//  Baud counter counts 0..B-1 and is width $clog2(B+1). At B-1 the bit ends and the counter wraps to 0.
//   It is held at 0 in IDLE and never free-runs across frames.
//  Timing: frame length F=B*(1+D+P+S) cycles, occupying T+1..T+F. At T+F+1 state=IDLE, done_o=1 and tx_ready_o=1.
//  Back-to-back: a handshake in the done_o cycle is legal. The next start bit then begins at T+F+2.
//   The minimum idle-high gap between frames is therefore 1 cycle plus the stop bit(s).
//  tx_ready_o=0 from T+1 through T+F. tx_valid_i is ignored while busy and may drop or toggle freely before a handshake.
//  tx_data_i changes after the handshake have no effect on the frame in flight.
//  done_o and busy_o are never high in the same cycle. done_o is never asserted twice for one frame.
// TESTING (B=5, D=8 unless stated)
//  1) Send 0xA5 with no parity, S=1 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each bit 5 cycles. done_o pulses at T+51; busy_o is high for T+1..T+50.
//  2) Send 0xA5 with PARITY_EN=1 -> even config: parity bit 0, F=55. PARITY_ODD=1: parity bit 1. done_o pulses at T+56.
//  3) Hold tx_valid_i=1 with 0x00 then 0xFF queued -> second handshake in the done_o cycle. The second start bit begins exactly 1 cycle after the first stop bit ends.
//  4) Change tx_data_i every cycle during a frame of 0x3C -> line still carries 0x3C. tx_ready_o stays 0 and there is no extra handshake.
//  5) Pull rst_ni low during DATA bit 3 -> tx_o=1 asynchronously with no done_o. After release, a new 0x81 frame is sent correctly.
//  6) B=1, STOP_BITS=2, 0x55 -> 1 cycle per bit, F=11. done_o at T+12 and the bit sequence is correct.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// Purpose    : transmit-side UART controller; one word per valid/ready handshake, serialised
//              LSB first as start, data, optional parity, stop bit(s) on a registered line.
// Latency    : start bit appears the cycle after the handshake; frame lasts B*(1+D+P+S) cycles.
// Backpressure: tx_ready_o is high only in IDLE; tx_valid_i is ignored while a frame is in flight.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset (line returns high at once, frame abandoned)
//   tx_data_i   word to send, sampled only on the handshake
//   tx_valid_i  producer has a word
//   tx_ready_o  controller can accept a word (combinational, state == IDLE)
//   tx_o        serial line, registered, idle high
//   busy_o      frame in progress (state != IDLE)
//   done_o      one-cycle pulse in the first IDLE cycle after a completed frame

module uart_tx_ctrl #(
    parameter int CLOCK        = 100_000_000,
    parameter int BAUD_RATE    = 20_000_000,
    parameter int BAUD_COUNTER = CLOCK / BAUD_RATE,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // Baud counter runs 0..B-1; width holds B so B=1 still gets a 1-bit counter.
    localparam int CNT_W = $clog2(BAUD_COUNTER + 1);
    // One index serves both data bits and stop bits (DATA_BITS always >= STOP_BITS).
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_COUNTER - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   word_q, word_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;

    logic                   bit_end;
    logic                   parity_bit;

    assign bit_end    = (cnt_q == CNT_LAST);
    // Parity is taken from the latched word; the shift register is consumed by then.
    assign parity_bit = PARITY_ODD ? ~(^word_q) : (^word_q);

    assign tx_ready_o = (state_q == IDLE);
    assign busy_o     = (state_q != IDLE);
    assign tx_o       = tx_q;
    assign done_o     = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. The counter is pinned to 0 in IDLE so every frame starts
    // with a full-length start bit regardless of how long the line was idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        done_d  = 1'b0;

        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (tx_valid_i) begin
                    word_d  = tx_data_i;
                    shift_d = tx_data_i;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // The line is registered, so its next value follows the state being entered:
    // a handshake in cycle T puts the start bit on tx_o in T+1.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_bit;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four instances cover the default frame,
// even and odd parity, and a 1-clock-per-bit / two-stop-bit configuration.
module tb_uart_tx_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dat [4];
    logic       vld [4];
    logic       rdy_w  [4];
    logic       tx_w   [4];
    logic       busy_w [4];
    logic       done_w [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle samples; index k is cycle T+k after the handshake cycle T.
    logic cap_tx   [0:127];
    logic cap_rdy  [0:127];
    logic cap_busy [0:127];
    logic cap_done [0:127];

    uart_tx_ctrl u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(dat[0]), .tx_valid_i(vld[0]),
        .tx_ready_o(rdy_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0])
    );

    uart_tx_ctrl #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(dat[1]), .tx_valid_i(vld[1]),
        .tx_ready_o(rdy_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1])
    );

    uart_tx_ctrl #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(dat[2]), .tx_valid_i(vld[2]),
        .tx_ready_o(rdy_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2])
    );

    uart_tx_ctrl #(.BAUD_COUNTER(1), .STOP_BITS(2)) u_fast (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(dat[3]), .tx_valid_i(vld[3]),
        .tx_ready_o(rdy_w[3]), .tx_o(tx_w[3]), .busy_o(busy_w[3]), .done_o(done_w[3])
    );

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sample(input int idx, input int k);
        cap_tx[k]   = tx_w[idx];
        cap_rdy[k]  = rdy_w[idx];
        cap_busy[k] = busy_w[idx];
        cap_done[k] = done_w[idx];
    endtask

    task automatic launch(input int idx, input logic [7:0] d);
        @(posedge clk); #1;
        dat[idx] = d;
        vld[idx] = 1'b1;
        @(posedge clk); #1;
        vld[idx] = 1'b0;
    endtask

    task automatic capture(input int idx, input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            sample(idx, k);
        end
    endtask

    task automatic test_reset();
        vld[0] = 1'b1;
        dat[0] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_w[0], busy_w[0], done_w[0], rdy_w[0]} !== 4'b1001) begin
                n_fail++;
                $display("FAIL reset_state cyc%0d: {tx,busy,done,rdy}=%b expected 1001", k,
                         {tx_w[0], busy_w[0], done_w[0], rdy_w[0]});
            end
        end
        n_checks++;
        if ({tx_w[3], busy_w[3]} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_fast: {tx,busy}=%b expected 10", {tx_w[3], busy_w[3]});
        end
        vld[0] = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({tx_w[0], busy_w[0], done_w[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL post_reset_idle: {tx,busy,done}=%b expected 100",
                     {tx_w[0], busy_w[0], done_w[0]});
        end
    endtask

    task automatic test_basic();
        logic [9:0] exp_bits;
        logic [4:0] obs;
        int bad_busy;
        int bad_rdy;
        exp_bits = 10'b1_10100101_0;  // bit0 = start, bits 1..8 = 0xA5 LSB first, bit9 = stop
        launch(0, 8'hA5);
        capture(0, 52);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 5; c++) obs[c] = cap_tx[5*j + c + 1];
            n_checks++;
            if (obs !== {5{exp_bits[j]}}) begin
                n_fail++;
                $display("FAIL basic_bit%0d: line=%b expected %b", j, obs, {5{exp_bits[j]}});
            end
        end
        bad_busy = 0;
        bad_rdy  = 0;
        for (int k = 1; k <= 50; k++) begin
            if (cap_busy[k] !== 1'b1 || cap_done[k] !== 1'b0) bad_busy++;
            if (cap_rdy[k] !== 1'b0) bad_rdy++;
        end
        n_checks++;
        if (bad_busy != 0) begin
            n_fail++;
            $display("FAIL basic_busy_window: %0d bad cycles expected 0", bad_busy);
        end
        n_checks++;
        if (bad_rdy != 0) begin
            n_fail++;
            $display("FAIL basic_ready_low: %0d cycles with ready high expected 0", bad_rdy);
        end
        n_checks++;
        if ({cap_done[51], cap_busy[51], cap_rdy[51], cap_tx[51]} !== 4'b1011) begin
            n_fail++;
            $display("FAIL basic_done_T51: {done,busy,rdy,tx}=%b expected 1011",
                     {cap_done[51], cap_busy[51], cap_rdy[51], cap_tx[51]});
        end
        n_checks++;
        if (cap_done[52] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_single: done at T+52=%b expected 0", cap_done[52]);
        end
    endtask

    task automatic test_parity();
        logic [10:0] exp_even;
        logic [10:0] exp_odd;
        logic [4:0]  obs;
        exp_even = 11'b1_0_10100101_0;  // parity of 0xA5 (four ones) is 0 for even
        exp_odd  = 11'b1_1_10100101_0;
        launch(1, 8'hA5);
        capture(1, 57);
        for (int j = 0; j < 11; j++) begin
            for (int c = 0; c < 5; c++) obs[c] = cap_tx[5*j + c + 1];
            n_checks++;
            if (obs !== {5{exp_even[j]}}) begin
                n_fail++;
                $display("FAIL even_bit%0d: line=%b expected %b", j, obs, {5{exp_even[j]}});
            end
        end
        n_checks++;
        if ({cap_busy[55], cap_done[55], cap_done[56], cap_busy[56], cap_done[57]} !== 5'b10100) begin
            n_fail++;
            $display("FAIL even_done_T56: {busy55,done55,done56,busy56,done57}=%b expected 10100",
                     {cap_busy[55], cap_done[55], cap_done[56], cap_busy[56], cap_done[57]});
        end
        launch(2, 8'hA5);
        capture(2, 57);
        for (int j = 0; j < 11; j++) begin
            for (int c = 0; c < 5; c++) obs[c] = cap_tx[5*j + c + 1];
            n_checks++;
            if (obs !== {5{exp_odd[j]}}) begin
                n_fail++;
                $display("FAIL odd_bit%0d: line=%b expected %b", j, obs, {5{exp_odd[j]}});
            end
        end
        n_checks++;
        if ({cap_done[55], cap_done[56], cap_busy[56]} !== 3'b010) begin
            n_fail++;
            $display("FAIL odd_done_T56: {done55,done56,busy56}=%b expected 010",
                     {cap_done[55], cap_done[56], cap_busy[56]});
        end
    endtask

    task automatic test_back_to_back();
        int bad_first;
        int bad_second;
        int n_done;
        @(posedge clk); #1;
        dat[0] = 8'h00;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        dat[0] = 8'hFF;  // queued word; valid stays high
        for (int k = 1; k <= 104; k++) begin
            @(negedge clk);
            sample(0, k);
            if (k == 60) vld[0] = 1'b0;
        end
        bad_first  = 0;
        bad_second = 0;
        n_done     = 0;
        for (int k = 6; k <= 45; k++) if (cap_tx[k] !== 1'b0) bad_first++;
        for (int k = 57; k <= 101; k++) if (cap_tx[k] !== 1'b1) bad_second++;
        for (int k = 1; k <= 104; k++) if (cap_done[k] === 1'b1) n_done++;
        n_checks++;
        if (bad_first != 0) begin
            n_fail++;
            $display("FAIL b2b_first_data: %0d bad cycles expected 0", bad_first);
        end
        n_checks++;
        if (bad_second != 0) begin
            n_fail++;
            $display("FAIL b2b_second_data_stop: %0d bad cycles expected 0", bad_second);
        end
        n_checks++;
        if ({cap_tx[50], cap_tx[51], cap_tx[52], cap_tx[56]} !== 4'b1100) begin
            n_fail++;
            $display("FAIL b2b_gap: tx@50,51,52,56=%b expected 1100",
                     {cap_tx[50], cap_tx[51], cap_tx[52], cap_tx[56]});
        end
        n_checks++;
        if ({cap_done[51], cap_rdy[51], cap_busy[51], cap_busy[52]} !== 4'b1101) begin
            n_fail++;
            $display("FAIL b2b_handshake: {done51,rdy51,busy51,busy52}=%b expected 1101",
                     {cap_done[51], cap_rdy[51], cap_busy[51], cap_busy[52]});
        end
        n_checks++;
        if (cap_done[102] !== 1'b1 || n_done != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: done102=%b count=%0d expected 1 and 2", cap_done[102], n_done);
        end
    endtask

    task automatic test_data_change();
        logic [9:0] exp_bits;
        logic [4:0] obs;
        int bad_rdy;
        int n_done;
        int late_busy;
        exp_bits = 10'b1_00111100_0;
        @(posedge clk); #1;
        dat[0] = 8'h3C;
        vld[0] = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 56; k++) begin
            @(negedge clk);
            sample(0, k);
            dat[0] = 8'($urandom());
            vld[0] = (k < 45) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 5; c++) obs[c] = cap_tx[5*j + c + 1];
            n_checks++;
            if (obs !== {5{exp_bits[j]}}) begin
                n_fail++;
                $display("FAIL chg_bit%0d: line=%b expected %b", j, obs, {5{exp_bits[j]}});
            end
        end
        bad_rdy   = 0;
        n_done    = 0;
        late_busy = 0;
        for (int k = 1; k <= 50; k++) if (cap_rdy[k] !== 1'b0) bad_rdy++;
        for (int k = 1; k <= 56; k++) if (cap_done[k] === 1'b1) n_done++;
        for (int k = 52; k <= 56; k++) if (cap_busy[k] !== 1'b0) late_busy++;
        n_checks++;
        if (bad_rdy != 0) begin
            n_fail++;
            $display("FAIL chg_ready_low: %0d cycles with ready high expected 0", bad_rdy);
        end
        n_checks++;
        if (cap_done[51] !== 1'b1 || n_done != 1 || late_busy != 0) begin
            n_fail++;
            $display("FAIL chg_no_extra: done51=%b dones=%0d late_busy=%0d expected 1,1,0",
                     cap_done[51], n_done, late_busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp_bits;
        logic [4:0] obs;
        int bad_idle;
        exp_bits = 10'b1_10000001_0;
        launch(0, 8'h00);
        capture(0, 21);  // cycle T+21 is the first cycle of data bit 3
        n_checks++;
        if ({tx_w[0], busy_w[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_pre: {tx,busy}=%b expected 01", {tx_w[0], busy_w[0]});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_w[0], busy_w[0], done_w[0], rdy_w[0]} !== 4'b1001) begin
            n_fail++;
            $display("FAIL rstmid_async: {tx,busy,done,rdy}=%b expected 1001",
                     {tx_w[0], busy_w[0], done_w[0], rdy_w[0]});
        end
        vld[0] = 1'b1;
        dat[0] = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        rst_n  = 1'b1;
        bad_idle = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) bad_idle++;
        end
        n_checks++;
        if (bad_idle != 0) begin
            n_fail++;
            $display("FAIL rstmid_idle_after: %0d bad cycles expected 0", bad_idle);
        end
        launch(0, 8'h81);
        capture(0, 52);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 5; c++) obs[c] = cap_tx[5*j + c + 1];
            n_checks++;
            if (obs !== {5{exp_bits[j]}}) begin
                n_fail++;
                $display("FAIL rstmid_0x81_bit%0d: line=%b expected %b", j, obs, {5{exp_bits[j]}});
            end
        end
        n_checks++;
        if ({cap_done[50], cap_done[51], cap_done[52]} !== 3'b010) begin
            n_fail++;
            $display("FAIL rstmid_done: done@50,51,52=%b expected 010",
                     {cap_done[50], cap_done[51], cap_done[52]});
        end
    endtask

    task automatic test_fast();
        logic [10:0] exp_bits;
        logic [10:0] obs;
        exp_bits = 11'b11_01010101_0;  // start, 0x55 LSB first, two stop bits
        launch(3, 8'h55);
        capture(3, 13);
        for (int k = 1; k <= 11; k++) obs[k-1] = cap_tx[k];
        n_checks++;
        if (obs !== exp_bits) begin
            n_fail++;
            $display("FAIL fast_bits: line=%b expected %b", obs, exp_bits);
        end
        n_checks++;
        if ({cap_busy[11], cap_done[11], cap_done[12], cap_busy[12], cap_rdy[12], cap_done[13]}
            !== 6'b101010) begin
            n_fail++;
            $display("FAIL fast_done_T12: {busy11,done11,done12,busy12,rdy12,done13}=%b expected 101010",
                     {cap_busy[11], cap_done[11], cap_done[12], cap_busy[12], cap_rdy[12], cap_done[13]});
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            dat[i] = 8'h00;
            vld[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_data_change();
        test_reset_mid();
        test_fast();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
